// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the fetch PC sequencer
package pc_seq_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC candidates: sequential, redirect/trap select, misalign flag
module pc_next_sel #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            ex_redirect_i,
  input  logic            ex_trap_i,
  input  logic [XLEN-1:0] ex_target_i,
  output logic [XLEN-1:0] pc_seq_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            misalign_o
);
  import pc_seq_pkg::*;

  // Trap wins over a branch; a misaligned branch target is turned into a trap.
  always_comb begin
    pc_seq_o      = pc_i + XLEN'(INSTR_BYTES);
    redirect_o    = ex_trap_i | ex_redirect_i;
    misalign_o    = ex_redirect_i && !ex_trap_i &&
                    ((ex_target_i[1:0] & MISALIGN_MASK) != 2'b00);
    redirect_pc_o = (ex_trap_i || misalign_o) ? TRAP_VEC : ex_target_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC owner and single-outstanding imem fetch sequencer
module pc_sequencer #(
  parameter int              XLEN     = pc_seq_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            if_ready,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_trap,
  output logic            misalign_err
);
  import pc_seq_pkg::*;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic            req_gap_q, req_gap_d;
  logic            misalign_q;

  logic [XLEN-1:0] pc_seq;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign;

  pc_next_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_sel (
    .pc_i          (pc_q),
    .ex_redirect_i (ex_redirect),
    .ex_trap_i     (ex_trap),
    .ex_target_i   (ex_target),
    .pc_seq_o      (pc_seq),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc),
    .misalign_o    (misalign)
  );

  // State, PC and the fetched-instruction holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      req_gap_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      req_gap_q  <= req_gap_d;
      misalign_q <= misalign;
    end
  end

  // Fetch sequencing; req_gap_q blanks imem_req for the cycle after an
  // ungranted request was redirected so the address change is never seen
  // mid-request by imem.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    req_gap_d  = 1'b0;
    imem_req   = 1'b0;
    if_valid   = 1'b0;
    case (state_q)
      REQ: begin
        imem_req = !req_gap_q;
        if (redirect) begin
          pc_d = redirect_pc;
          if (!req_gap_q && imem_gnt) state_d = DROP;
          else                        req_gap_d = 1'b1;
        end else if (!req_gap_q && imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if_valid = 1'b1;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (if_ready) begin
          pc_d    = pc_seq;
          state_d = REQ;
        end
      end
      DROP: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  assign imem_addr    = pc_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        ex_trap;
  logic        misalign_err;

  int          checks = 0;
  int          errors = 0;
  int          rv_delay = 1;
  logic [31:0] exp_addr[$];
  fetch_t      exp_fetch[$];

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_ready     (if_ready),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .ex_trap      (ex_trap),
    .misalign_err (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a == 32'h0000_000C) ? 32'h00A0_0093 : {a[15:0], 16'h0013};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_fetch.push_back('{a, instr_of(a)});
  endtask

  task automatic wait_drain(input string name, input int maxc);
    bit done = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      tick();
      if (exp_addr.size() == 0 && exp_fetch.size() == 0) done = 1;
    end
    if (!done) fail_now(name, 32'(exp_addr.size() + exp_fetch.size()));
  endtask

  task automatic wait_valid(input string name, input int maxc);
    bit done = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      tick();
      if (if_valid) done = 1;
    end
    if (!done) fail_now(name, {31'd0, if_valid});
  endtask

  // imem model: one outstanding request, response rv_delay cycles after grant
  initial begin
    logic        busy;
    int          cnt;
    logic [31:0] gaddr;
    busy = 1'b0;
    cnt = 0;
    gaddr = '0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
      end else if (imem_req && imem_gnt) begin
        busy = 1'b1;
        cnt = rv_delay;
        gaddr = imem_addr;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (rst_n && busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = instr_of(gaddr);
          busy = 1'b0;
        end
      end
    end
  end

  // monitor: pops expected request addresses and delivered instructions
  initial begin
    logic [31:0] ea;
    fetch_t      ef;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req && imem_gnt) begin
          if (exp_addr.size() == 0) fail_now("unexpected_req", imem_addr);
          else begin
            ea = exp_addr.pop_front();
            check("imem_addr", imem_addr, ea);
          end
        end
        if (if_valid && if_ready) begin
          if (exp_fetch.size() == 0) fail_now("unexpected_fetch", if_pc);
          else begin
            ef = exp_fetch.pop_front();
            check("if_pc", if_pc, ef.pc);
            check("if_instr", if_instr, ef.instr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    if_ready = 1'b0;
    ex_redirect = 1'b0;
    ex_trap = 1'b0;
    ex_target = '0;
    tick();
    tick();
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // 1: back-to-back sequential fetches
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8);
    if_ready = 1'b1;
    imem_gnt = 1'b1;
    wait_drain("t1_drain", 40);
    imem_gnt = 1'b0;

    // 2: decode stalls for 5 cycles while an instruction is held
    if_ready = 1'b0;
    exp_addr.push_back(32'hC);
    imem_gnt = 1'b1;
    wait_valid("t2_valid", 20);
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_valid_hold", {31'd0, if_valid}, 32'd1);
      check("t2_pc_hold", if_pc, 32'hC);
      check("t2_instr_hold", if_instr, 32'h00A0_0093);
      check("t2_no_req", {31'd0, imem_req}, 32'd0);
    end
    push_fetch(32'hC);
    exp_addr.push_back(32'h10);
    push_fetch(32'h10);
    if_ready = 1'b1;
    imem_gnt = 1'b1;
    wait_drain("t2_drain", 40);
    imem_gnt = 1'b0;

    // 3: redirect while waiting; late response must be dropped
    rv_delay = 3;
    exp_addr.push_back(32'h14);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    ex_redirect = 1'b1;
    ex_target = 32'h100;
    check("t3_wait_req", {31'd0, imem_req}, 32'd0);
    tick();
    ex_redirect = 1'b0;
    check("t3_drop_valid", {31'd0, if_valid}, 32'd0);
    check("t3_drop_addr", imem_addr, 32'h100);
    tick();
    check("t3_drop_req", {31'd0, imem_req}, 32'd0);
    check("t3_drop_valid2", {31'd0, if_valid}, 32'd0);
    tick();
    check("t3_req_again", {31'd0, imem_req}, 32'd1);
    check("t3_req_addr", imem_addr, 32'h100);
    check("t3_valid_low", {31'd0, if_valid}, 32'd0);
    rv_delay = 1;
    exp_addr.push_back(32'h100);
    push_fetch(32'h100);
    imem_gnt = 1'b1;
    wait_drain("t3_drain", 40);
    imem_gnt = 1'b0;

    // 4: misaligned redirect in REQ without grant
    ex_redirect = 1'b1;
    ex_target = 32'h102;
    tick();
    ex_redirect = 1'b0;
    check("t4_misalign_pulse", {31'd0, misalign_err}, 32'd1);
    check("t4_req_gap", {31'd0, imem_req}, 32'd0);
    check("t4_trap_addr", imem_addr, 32'h100);
    tick();
    check("t4_misalign_clear", {31'd0, misalign_err}, 32'd0);
    check("t4_req_back", {31'd0, imem_req}, 32'd1);
    check("t4_addr_back", imem_addr, 32'h100);
    exp_addr.push_back(32'h100);
    push_fetch(32'h100);
    imem_gnt = 1'b1;
    wait_drain("t4_drain", 40);
    imem_gnt = 1'b0;

    // 5: trap beats redirect in HOLD with simultaneous accept; then PC wrap
    if_ready = 1'b0;
    exp_addr.push_back(32'h104);
    imem_gnt = 1'b1;
    wait_valid("t5_valid", 20);
    imem_gnt = 1'b0;
    push_fetch(32'h104);
    ex_trap = 1'b1;
    ex_redirect = 1'b1;
    ex_target = 32'h40;
    if_ready = 1'b1;
    tick();
    ex_trap = 1'b0;
    ex_redirect = 1'b0;
    check("t5_valid_drop", {31'd0, if_valid}, 32'd0);
    check("t5_trap_addr", imem_addr, 32'h100);
    check("t5_no_misalign", {31'd0, misalign_err}, 32'd0);
    check("t5_req", {31'd0, imem_req}, 32'd1);
    ex_redirect = 1'b1;
    ex_target = 32'hFFFF_FFFC;
    tick();
    ex_redirect = 1'b0;
    check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    check("t5_top_gap", {31'd0, imem_req}, 32'd0);
    exp_addr.push_back(32'hFFFF_FFFC);
    push_fetch(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    push_fetch(32'h0);
    imem_gnt = 1'b1;
    wait_drain("t5_drain", 40);
    imem_gnt = 1'b0;

    // 6: asynchronous reset while waiting for a response
    rv_delay = 3;
    exp_addr.push_back(32'h4);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("t6_wait_req", {31'd0, imem_req}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'd0, imem_req}, 32'd1);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_valid", {31'd0, if_valid}, 32'd0);
    check("t6_rst_instr", if_instr, 32'h0);
    check("t6_rst_pc", if_pc, 32'h0);
    check("t6_rst_misalign", {31'd0, misalign_err}, 32'd0);
    tick();
    tick();
    rv_delay = 1;
    rst_n = 1'b1;
    #1;
    check("t6_restart_req", {31'd0, imem_req}, 32'd1);
    check("t6_restart_addr", imem_addr, 32'h0);
    exp_addr.push_back(32'h0);
    push_fetch(32'h0);
    imem_gnt = 1'b1;
    wait_drain("t6_drain", 40);
    imem_gnt = 1'b0;
    tick();
    tick();
    check("final_addr_q", 32'(exp_addr.size()), 32'd0);
    check("final_fetch_q", 32'(exp_fetch.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
